rdoq_coef_quantizer: RTL and testbench
======================================

// Module: rdoq_coef_quantizer
// PURPOSE
//  Scalar forward quantizer. Sits directly downstream of the quantization-bits calculator and
//  consumes its iQBits result (14..33) as cfg_qbits. Quantizes one transform coefficient per beat:
//  level = sign(c) * min(((|c|*scale[qp_rem] + offset) >> qbits), LEVEL_MAX).
//  3-stage valid/ready pipeline; feeds the RDOQ cost stage with levels and per-block non-zero counts.
// PARAMETERS
//  COEF_W   16  signed input coefficient width
//  LEVEL_W  16  signed output level width; LEVEL_MAX = 2^(LEVEL_W-1)-1
//  CNT_W    11  non-zero counter width (1024 coefs per 32x32 TU)
// PORTS
//  clk           in   1        rising-edge clock
//  rst_n         in   1        asynchronous active-low reset
//  in_valid      in   1        coefficient beat valid
//  in_ready      out  1        beat accepted when in_valid & in_ready
//  in_coef       in   COEF_W   signed coefficient
//  in_last       in   1        last coefficient of the TU
//  cfg_qbits     in   6        iQBits from the bits calculator, 14..33; sampled with each beat
//  cfg_qp_rem    in   3        QP % 6, 0..5; sampled with each beat
//  cfg_is_intra  in   1        1: offset 171<<(qbits-9), 0: offset 85<<(qbits-9)
//  out_valid     out  1        level beat valid
//  out_ready     in   1        downstream accepts when out_valid & out_ready
//  out_level     out  LEVEL_W  signed quantized level
//  out_last      out  1        in_last delayed with its beat
//  out_nz_count  out  CNT_W    non-zero levels in the TU incl. this beat; meaningful when out_last=1
//  out_delta     out  9        signed rounding error for RDOQ (only when RDOQ_DELTA_EN defined)
// BEHAVIOUR
//  Reset: all stage valids 0; out_valid=0, out_level=0, out_last=0, out_nz_count=0, out_delta=0.
//  Pipeline: global advance en = !s3_valid | out_ready; in_ready = en (combinational).
//   Stalled stages hold data and valid unchanged. Bubbles (invalid stages) also shift on en.
//   Latency 3 cycles from accept to out_valid with out_ready held high; throughput 1 beat/cycle.
//  S1: mag = |in_coef| (17 bit; -32768 -> 32768); sign = in_coef<0;
//   scale LUT qp_rem 0..5 = 26214,23302,20560,18396,16384,14564; qp_rem 6,7 -> 26214.
//   offset = (intra ? 171 : 85) << (qbits-9); qbits <14 treated as 14, >33 treated as 33.
//  S2: prod = mag*scale (32 bit unsigned); sum = prod + offset (33 bit, no overflow).
//  S3: q = sum >> qbits; mag_c = min(q, LEVEL_MAX); out_level = sign ? -mag_c : mag_c;
//   mag_c==0 -> out_level=0 regardless of sign.
//  NZ count: internal cnt advances only on output handshake; out_nz_count = cnt + (out_level!=0).
//   On handshake with out_last=1, cnt clears to 0; otherwise cnt <= out_nz_count.
//   Counter saturates at 2^CNT_W-1 (never wraps).
//  out_last/config travel with their beat; config changes mid-TU are applied per beat.
//  Reset mid-operation: all in-flight beats discarded, cnt cleared; no partial output.
// CONFIGURATION
//  RDOQ_DELTA_EN defined: S2 also carries prod; S3 computes
//   out_delta = (prod - (q << qbits)) >>> (qbits-8), signed 9 bit, range -255..255
//   (q unclamped), registered with out_level.
//  Not defined: out_delta port and its datapath absent; all other behaviour identical.
// TESTING
//  T1 coef=1000, qp_rem=0, qbits=20, intra -> level=25 after 3 cycles; delta=-1 (RDOQ_DELTA_EN).
//  T2 coef=-1000, same cfg -> level=-25; coef=30 intra -> 1, coef=30 inter -> 0.
//  T3 coef=-32768, qp_rem=0, qbits=14, intra -> level=-32767 (clamp); coef=3, qbits=33 -> 0.
//  T4 TU of 16 beats, 5 non-zero levels, last on beat 16 -> out_nz_count=5 on last; next TU starts at 0.
//  T5 out_ready random 50%, 200 random beats -> no loss/duplication, order kept, in_ready=0 only
//     while s3_valid & !out_ready; matches reference model.
//  T6 rst_n asserted with 3 beats in flight -> out_valid=0 immediately, cnt=0, next TU counts from 0.

Source files
------------

// File: rtl/rdoq_coef_quantizer.sv
// rdoq_coef_quantizer: scalar forward quantizer, 3-stage valid/ready pipeline.
// S1 takes the magnitude and looks up scale/offset, S2 multiplies and adds,
// S3 shifts, clamps, restores the sign and registers the output beat.
// Optional feature macro: RDOQ_DELTA_EN adds the out_delta rounding-error output.
module rdoq_coef_quantizer #(
    parameter int COEF_W  = 16,
    parameter int LEVEL_W = 16,
    parameter int CNT_W   = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COEF_W-1:0]  in_coef,
    input  logic               in_last,
    input  logic [5:0]         cfg_qbits,
    input  logic [2:0]         cfg_qp_rem,
    input  logic               cfg_is_intra,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LEVEL_W-1:0] out_level,
    output logic               out_last,
`ifdef RDOQ_DELTA_EN
    output logic [8:0]         out_delta,
`endif
    output logic [CNT_W-1:0]   out_nz_count
);

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = {1'b0, {(LEVEL_W-1){1'b1}}};
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

    // One global advance: a stage only moves when the output slot frees up.
    logic       en;
    logic [3:1] vldPipe;

    assign en       = !vldPipe[3] || out_ready;
    assign in_ready = en;
    assign out_valid = vldPipe[3];

    // ---------------- S1 combinational front end ----------------
    logic [COEF_W:0] magIn;
    logic [14:0]     scaleIn;
    logic [5:0]      qbitsIn;
    logic [31:0]     offsetIn;

    // Magnitude, scale LUT, clamped qbits and rounding offset for the incoming beat.
    always_comb begin
        magIn = in_coef[COEF_W-1] ? ({(COEF_W+1){1'b0}} - {1'b1, in_coef}) : {1'b0, in_coef};
        case (cfg_qp_rem)
            3'd1:    scaleIn = 15'd23302;
            3'd2:    scaleIn = 15'd20560;
            3'd3:    scaleIn = 15'd18396;
            3'd4:    scaleIn = 15'd16384;
            3'd5:    scaleIn = 15'd14564;
            default: scaleIn = 15'd26214;
        endcase
        if (cfg_qbits < 6'd14)      qbitsIn = 6'd14;
        else if (cfg_qbits > 6'd33) qbitsIn = 6'd33;
        else                        qbitsIn = cfg_qbits;
        offsetIn = (cfg_is_intra ? 32'd171 : 32'd85) << (qbitsIn - 6'd9);
    end

    // ---------------- S1 registers ----------------
    logic [COEF_W:0] s1Mag;
    logic            s1Sign, s1Last;
    logic [14:0]     s1Scale;
    logic [5:0]      s1Qbits;
    logic [31:0]     s1Offset;

    // ---------------- S2 registers ----------------
    logic            s2Sign, s2Last;
    logic [5:0]      s2Qbits;
    logic [32:0]     s2Sum;
    logic [31:0]     s2Prod;

    // Valid shift register; bubbles shift along with real beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  vldPipe <= '0;
        else if (en) vldPipe <= {vldPipe[2:1], in_valid};
    end

    // S1 capture: beat data plus its own per-beat configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Mag    <= '0;
            s1Sign   <= 1'b0;
            s1Last   <= 1'b0;
            s1Scale  <= '0;
            s1Qbits  <= 6'd14;
            s1Offset <= '0;
        end else if (en) begin
            s1Mag    <= magIn;
            s1Sign   <= in_coef[COEF_W-1];
            s1Last   <= in_last;
            s1Scale  <= scaleIn;
            s1Qbits  <= qbitsIn;
            s1Offset <= offsetIn;
        end
    end

    logic [31:0] prodS1;
    assign prodS1 = 32'(s1Mag) * 32'(s1Scale);

    // S2: product and rounded sum (33 bits so the add never overflows).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2Sign  <= 1'b0;
            s2Last  <= 1'b0;
            s2Qbits <= 6'd14;
            s2Sum   <= '0;
            s2Prod  <= '0;
        end else if (en) begin
            s2Sign  <= s1Sign;
            s2Last  <= s1Last;
            s2Qbits <= s1Qbits;
            s2Sum   <= {1'b0, prodS1} + {1'b0, s1Offset};
            s2Prod  <= prodS1;
        end
    end

    // ---------------- S3 combinational back end ----------------
    logic [32:0]        qRaw;
    logic [LEVEL_W-1:0] magC, levelNext;

    // Shift down, clamp to the level range, then re-apply the sign (zero stays zero).
    always_comb begin
        qRaw      = s2Sum >> s2Qbits;
        magC      = (qRaw > 33'(LEVEL_MAX)) ? LEVEL_MAX : qRaw[LEVEL_W-1:0];
        levelNext = s2Sign ? ({LEVEL_W{1'b0}} - magC) : magC;
    end

`ifdef RDOQ_DELTA_EN
    logic [32:0]        qBack;
    logic signed [33:0] diff, diffSh;
    logic [5:0]         dShift;

    // Rounding error of the unclamped quotient, scaled to 8 fractional bits.
    always_comb begin
        qBack  = qRaw << s2Qbits;
        diff   = signed'({2'b00, s2Prod}) - signed'({1'b0, qBack});
        dShift = s2Qbits - 6'd8;
        diffSh = diff >>> dShift;
    end

    // Delta is registered alongside the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  out_delta <= '0;
        else if (en) out_delta <= diffSh[8:0];
    end
`endif

    // S3 output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_level <= '0;
            out_last  <= 1'b0;
        end else if (en) begin
            out_level <= levelNext;
            out_last  <= s2Last;
        end
    end

    // ---------------- non-zero counter ----------------
    logic [CNT_W-1:0] cnt;

    // Running count including the presented beat, saturating at the top.
    always_comb begin
        if (cnt == CNT_MAX) out_nz_count = CNT_MAX;
        else                out_nz_count = cnt + CNT_W'(|out_level);
    end

    // Commit only on output handshake; a TU's last beat restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      cnt <= '0;
        else if (out_valid && out_ready) cnt <= out_last ? '0 : out_nz_count;
    end

endmodule

// File: tb/tb_rdoq_coef_quantizer.sv
// Scoreboard bench for rdoq_coef_quantizer: driver pushes model results into a
// queue, monitor pops on each output handshake and compares.
module tb_rdoq_coef_quantizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_coef = '0;
    logic        in_last = 1'b0;
    logic [5:0]  cfg_qbits = 6'd20;
    logic [2:0]  cfg_qp_rem = '0;
    logic        cfg_is_intra = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_level;
    logic        out_last;
    logic [10:0] out_nz_count;
`ifdef RDOQ_DELTA_EN
    logic [8:0]  out_delta;
`endif

    rdoq_coef_quantizer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_coef(in_coef), .in_last(in_last), .cfg_qbits(cfg_qbits),
        .cfg_qp_rem(cfg_qp_rem), .cfg_is_intra(cfg_is_intra),
        .out_valid(out_valid), .out_ready(out_ready), .out_level(out_level),
        .out_last(out_last),
`ifdef RDOQ_DELTA_EN
        .out_delta(out_delta),
`endif
        .out_nz_count(out_nz_count)
    );

    always #5 clk = ~clk;

    typedef struct { int lvl; bit last; int nz; int dlt; } exp_t;
    exp_t expQ[$];
    int   compared = 0, mismatched = 0;
    int   tbCnt = 0;
    int   readyMode = 1;   // 0 random, 1 always, 2 never

    task automatic check(input string name, input longint act, input longint req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference quantizer from the arithmetic definition.
    function automatic void model(input int coef, input int qbIn, input int qr, input bit intra,
                                  output int lvl, output int dlt);
        longint mag, scale, off, prod, q, mc;
        int qb;
        int scales[6] = '{26214, 23302, 20560, 18396, 16384, 14564};
        qb    = qbIn < 14 ? 14 : (qbIn > 33 ? 33 : qbIn);
        mag   = coef < 0 ? -coef : coef;
        scale = qr < 6 ? scales[qr] : 26214;
        off   = longint'(intra ? 171 : 85) << (qb - 9);
        prod  = mag * scale;
        q     = (prod + off) >> qb;
        mc    = q > 32767 ? 32767 : q;
        lvl   = coef < 0 ? -int'(mc) : int'(mc);
        dlt   = int'((prod - (q << qb)) >>> (qb - 8));
    endfunction

    task automatic send(input int coef, input int qb, input int qr, input bit intra, input bit last);
        bit acc;
        exp_t e;
        int waits = 0;
        @(negedge clk); #1;
        in_valid = 1'b1; in_coef = 16'(coef); cfg_qbits = 6'(qb);
        cfg_qp_rem = 3'(qr); cfg_is_intra = intra; in_last = last;
        forever begin
            #3;
            acc = in_ready;
            if (acc) begin
                model(coef, qb, qr, intra, e.lvl, e.dlt);
                if (e.lvl != 0 && tbCnt < 2047) tbCnt++;
                e.nz = tbCnt; e.last = last;
                if (last) tbCnt = 0;
                expQ.push_back(e);
            end
            @(posedge clk);
            if (acc) break;
            waits++;
            if (waits > 500) begin
                check("accept_timeout", waits, 0);
                break;
            end
            @(negedge clk); #1;
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        readyMode = 1;
        while (expQ.size() != 0 && n < 1000) begin @(posedge clk); n++; end
        check("drain_left", expQ.size(), 0);
    endtask

    // Monitor: drive out_ready after the edge, sample handshake mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            out_ready = (readyMode == 1) ? 1'b1 : (readyMode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rst_n) begin
                check("in_ready", in_ready, !(out_valid && !out_ready));
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) check("unexpected_beat", 1, 0);
                    else begin
                        e = expQ.pop_front();
                        check("level", $signed(out_level), e.lvl);
                        check("last", out_last, e.last);
                        check("nz_count", out_nz_count, e.nz);
`ifdef RDOQ_DELTA_EN
                        check("delta", $signed(out_delta), e.dlt);
`endif
                    end
                end
            end
        end
    end

    initial begin
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_level", out_level, 0);
        check("rst_out_last", out_last, 0);
        check("rst_nz_count", out_nz_count, 0);
        @(negedge clk); rst_n = 1'b1;
        readyMode = 1;

        // T1/T2/T3 directed points
        send(1000, 20, 0, 1, 0);
        send(-1000, 20, 0, 1, 0);
        send(30, 20, 0, 1, 0);
        send(30, 20, 0, 0, 0);
        send(-32768, 14, 0, 1, 0);
        send(3, 33, 0, 1, 1);
        send(-5, 10, 7, 0, 0);      // qbits below range, qp_rem 7
        send(32767, 40, 6, 1, 1);   // qbits above range
        drain();

        // T4: 16 beats, 5 non-zero, last on beat 16; then a fresh TU
        for (int i = 0; i < 16; i++)
            send((i % 3 == 0 && i < 13) ? 1000 : 0, 20, 0, 1, i == 15);
        for (int i = 0; i < 4; i++) send(-1000, 20, 0, 1, i == 3);
        drain();

        // T5: random data, random backpressure
        readyMode = 0;
        for (int i = 0; i < 200; i++)
            send(int'($signed(16'($urandom))) >>> $urandom_range(0, 12), $urandom_range(12, 35),
                 $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7) == 0);
        drain();

        // Counter saturation across a long TU
        for (int i = 0; i < 2060; i++) send(1000, 20, 0, 1, i == 2059);
        drain();

        // T6: reset with the pipeline full and a partial count
        for (int i = 0; i < 3; i++) send(1000, 20, 0, 1, 0);
        drain();
        readyMode = 2;
        for (int i = 0; i < 3; i++) send(2000, 20, 1, 0, 0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_nz_count", out_nz_count, 0);
        check("mid_rst_out_level", out_level, 0);
        expQ.delete();
        tbCnt = 0;
        @(negedge clk); rst_n = 1'b1;
        readyMode = 1;
        for (int i = 0; i < 4; i++) send(i == 1 ? 0 : 1000, 20, 0, 1, i == 3);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
